// File: rtl/axi4_rch_drop_sender.sv
// rtl/axi4_rch_drop_sender.sv - R-channel drop sender: forwards master read bursts, synthesises bursts for dropped reads
// RAB_RDROP_SLVERR_EN makes synthetic beats carry SLVERR instead of OKAY.
module axi4_rch_drop_sender #(
  parameter int C_AXI_ID_WIDTH   = 10,
  parameter int C_AXI_DATA_WIDTH = 64,
  parameter int C_AXI_USER_WIDTH = 4,
  parameter int DROP_FIFO_DEPTH  = 4
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arstn,
  input  logic [C_AXI_ID_WIDTH-1:0]   trans_id,
  input  logic [7:0]                  trans_len,
  input  logic                        trans_drop,
  output logic                        trans_ready,
  output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_rid,
  output logic [C_AXI_DATA_WIDTH-1:0] s_axi4_rdata,
  output logic [1:0]                  s_axi4_rresp,
  output logic                        s_axi4_rlast,
  output logic [C_AXI_USER_WIDTH-1:0] s_axi4_ruser,
  output logic                        s_axi4_rvalid,
  input  logic                        s_axi4_rready,
  input  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0] m_axi4_rdata,
  input  logic [1:0]                  m_axi4_rresp,
  input  logic                        m_axi4_rlast,
  input  logic [C_AXI_USER_WIDTH-1:0] m_axi4_ruser,
  input  logic                        m_axi4_rvalid,
  output logic                        m_axi4_rready
);

  localparam int AW = $clog2(DROP_FIFO_DEPTH);
  localparam int EW = C_AXI_ID_WIDTH + 8;

`ifdef RAB_RDROP_SLVERR_EN
  localparam logic [1:0] DROP_RESP = 2'b10;
`else
  localparam logic [1:0] DROP_RESP = 2'b00;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [EW-1:0]             r_fifo_mem [DROP_FIFO_DEPTH];
  logic [AW:0]               r_wr_ptr;
  logic [AW:0]               r_rd_ptr;
  logic [7:0]                r_count;

  logic                      w_empty;
  logic                      w_full;
  logic                      w_push;
  logic                      w_pop;
  logic [EW-1:0]             w_head;
  logic [C_AXI_ID_WIDTH-1:0] w_head_id;
  logic [7:0]                w_head_len;
  logic                      w_last_beat;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign trans_ready = !w_full;
  assign w_push      = trans_drop && !w_full;
  assign w_head      = r_fifo_mem[r_rd_ptr[AW-1:0]];
  assign w_head_id   = w_head[EW-1:8];
  assign w_head_len  = w_head[7:0];
  assign w_last_beat = (r_count == w_head_len);
  assign w_pop       = (r_state == ST_DROP) && s_axi4_rready && w_last_beat;

  always_ff @(posedge axi4_aclk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr[AW-1:0]] <= {trans_id, trans_len};
    end
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if ((r_state == ST_DROP) && s_axi4_rready) begin
        r_count <= w_last_beat ? 8'd0 : r_count + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    s_axi4_rid    = m_axi4_rid;
    s_axi4_rdata  = m_axi4_rdata;
    s_axi4_rresp  = m_axi4_rresp;
    s_axi4_rlast  = m_axi4_rlast;
    s_axi4_ruser  = m_axi4_ruser;
    s_axi4_rvalid = m_axi4_rvalid;
    m_axi4_rready = s_axi4_rready;
    case (r_state)
      ST_IDLE: begin
        // Pending drops win at a burst boundary; this cycle is the bubble.
        if (!w_empty) begin
          s_axi4_rvalid = 1'b0;
          m_axi4_rready = 1'b0;
          w_state_next  = ST_DROP;
        end else if (m_axi4_rvalid && !(s_axi4_rready && m_axi4_rlast)) begin
          w_state_next = ST_PASS;
        end
      end
      ST_PASS: begin
        if (m_axi4_rvalid && s_axi4_rready && m_axi4_rlast) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DROP: begin
        s_axi4_rid    = w_head_id;
        s_axi4_rdata  = '0;
        s_axi4_rresp  = DROP_RESP;
        s_axi4_rlast  = w_last_beat;
        s_axi4_ruser  = '0;
        s_axi4_rvalid = 1'b1;
        m_axi4_rready = 1'b0;
        if (s_axi4_rready && w_last_beat) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_rch_drop_sender.sv
// tb/tb_axi4_rch_drop_sender.sv - scoreboard bench for axi4_rch_drop_sender
module tb_axi4_rch_drop_sender;

  localparam int IDW = 10;
  localparam int DW  = 64;
  localparam int UW  = 4;

`ifdef RAB_RDROP_SLVERR_EN
  localparam logic [1:0] DROP_RESP = 2'b10;
`else
  localparam logic [1:0] DROP_RESP = 2'b00;
`endif

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
    logic [UW-1:0]  user;
  } beat_t;

  logic           axi4_aclk = 1'b0;
  logic           axi4_arstn;
  logic [IDW-1:0] trans_id;
  logic [7:0]     trans_len;
  logic           trans_drop;
  logic           trans_ready;
  logic [IDW-1:0] s_rid;
  logic [DW-1:0]  s_rdata;
  logic [1:0]     s_rresp;
  logic           s_rlast;
  logic [UW-1:0]  s_ruser;
  logic           s_rvalid;
  logic           s_rready;
  logic [IDW-1:0] m_rid;
  logic [DW-1:0]  m_rdata;
  logic [1:0]     m_rresp;
  logic           m_rlast;
  logic [UW-1:0]  m_ruser;
  logic           m_rvalid;
  logic           m_rready;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_beats  = 0;
  bit    m_hs;
  bit    d_hs;

  axi4_rch_drop_sender #(
    .C_AXI_ID_WIDTH(IDW), .C_AXI_DATA_WIDTH(DW),
    .C_AXI_USER_WIDTH(UW), .DROP_FIFO_DEPTH(4)
  ) dut (
    .axi4_aclk(axi4_aclk), .axi4_arstn(axi4_arstn),
    .trans_id(trans_id), .trans_len(trans_len),
    .trans_drop(trans_drop), .trans_ready(trans_ready),
    .s_axi4_rid(s_rid), .s_axi4_rdata(s_rdata), .s_axi4_rresp(s_rresp),
    .s_axi4_rlast(s_rlast), .s_axi4_ruser(s_ruser), .s_axi4_rvalid(s_rvalid),
    .s_axi4_rready(s_rready),
    .m_axi4_rid(m_rid), .m_axi4_rdata(m_rdata), .m_axi4_rresp(m_rresp),
    .m_axi4_rlast(m_rlast), .m_axi4_ruser(m_ruser), .m_axi4_rvalid(m_rvalid),
    .m_axi4_rready(m_rready)
  );

  always #5 axi4_aclk = ~axi4_aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  // One clock: sample at the falling edge, score any slave-side transfer,
  // queue expectations for an accepted drop, then return 1 time unit after the rise.
  task automatic cycle();
    beat_t got;
    beat_t e;
    @(negedge axi4_aclk);
    m_hs = m_rvalid && m_rready;
    d_hs = trans_drop && trans_ready;
    if (axi4_arstn && s_rvalid && s_rready) begin
      n_beats++;
      n_checks++;
      got = {s_rid, s_rdata, s_rresp, s_rlast, s_ruser};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got %h, required no beat", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL beat_compare: got %h, required %h", got, e);
        end
      end
    end
    if (d_hs) begin
      for (int i = 0; i <= int'(trans_len); i++) begin
        exp_q.push_back({trans_id, {DW{1'b0}}, DROP_RESP, (i == int'(trans_len)), {UW{1'b0}}});
      end
    end
    @(posedge axi4_aclk);
    #1;
  endtask

  task automatic push_drop(input logic [IDW-1:0] id, input logic [7:0] len);
    int k = 0;
    trans_id   = id;
    trans_len  = len;
    trans_drop = 1'b1;
    do begin
      cycle();
      k++;
    end while (!d_hs && k < 50);
    trans_drop = 1'b0;
    n_checks++;
    if (!d_hs) begin
      n_fail++;
      $display("FAIL push_accept: id=%h not accepted within %0d cycles, required acceptance", id, k);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cycle();
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic drive_m(input logic valid, input logic [IDW-1:0] id, input logic [DW-1:0] data,
                         input logic [1:0] resp, input logic last, input logic [UW-1:0] user);
    m_rvalid = valid;
    m_rid    = id;
    m_rdata  = data;
    m_rresp  = resp;
    m_rlast  = last;
    m_ruser  = user;
  endtask

  task automatic test_reset();
    axi4_arstn = 1'b0;
    trans_drop = 1'b0;
    trans_id   = '0;
    trans_len  = '0;
    s_rready   = 1'b1;
    drive_m(1'b1, 10'h0F0, 64'h1234, 2'b00, 1'b0, 4'h3);
    #1;
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rid !== 10'h0F0) begin
      n_fail++;
      $display("FAIL reset_passthrough: got valid=%b id=%h, required 1 0f0", s_rvalid, s_rid);
    end
    n_checks++;
    if (trans_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_trans_ready: got %b, required 1", trans_ready);
    end
    s_rready = 1'b0;
    #1;
    n_checks++;
    if (m_rready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rready: got %b, required 0", m_rready);
    end
    drive_m(1'b0, '0, '0, 2'b00, 1'b0, '0);
    s_rready = 1'b1;
    cycle();
    cycle();
    axi4_arstn = 1'b1;
    cycle();
  endtask

  task automatic test_passthrough();
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    s_rready = 1'b1;
    drive_m(1'b1, 10'h321, d, 2'b01, 1'b1, 4'h5);
    exp_q.push_back({10'h321, d, 2'b01, 1'b1, 4'h5});
    #1;
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== d || m_rready !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_zero_latency: got valid=%b data=%h rdy=%b, required 1 %h 1", s_rvalid, s_rdata, m_rready, d);
    end
    cycle();
    drive_m(1'b0, '0, '0, 2'b00, 1'b0, '0);
    // A single-beat burst must leave the block in IDLE so a drop is still served.
    push_drop(10'h055, 8'd0);
    drain("pass_then_drop", 10);
  endtask

  task automatic test_single_drop();
    s_rready = 1'b1;
    push_drop(10'h155, 8'd3);
    n_checks++;
    if (s_rvalid !== 1'b0 || m_rready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_bubble: got valid=%b m_rready=%b, required 0 0", s_rvalid, m_rready);
    end
    cycle();
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rid !== 10'h155 || s_rlast !== 1'b0) begin
      n_fail++;
      $display("FAIL single_first_beat: got valid=%b id=%h last=%b, required 1 155 0", s_rvalid, s_rid, s_rlast);
    end
    drain("single", 20);
    n_checks++;
    if (m_rready !== 1'b1 || s_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: got m_rready=%b s_rvalid=%b, required 1 0", m_rready, s_rvalid);
    end
  endtask

  task automatic test_drop_mid_master();
    logic [DW-1:0] d [3];
    int idx = 0;
    bit pushed = 0;
    s_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d[i] = {$urandom, $urandom};
      exp_q.push_back({10'h2A0, d[i], 2'b00, (i == 2), 4'hA});
    end
    drive_m(1'b1, 10'h2A0, d[0], 2'b00, 1'b0, 4'hA);
    for (int k = 0; k < 20 && idx < 3; k++) begin
      if (idx == 1 && !pushed) begin
        trans_id   = 10'h003;
        trans_len  = 8'd1;
        trans_drop = 1'b1;
      end
      cycle();
      if (d_hs) begin
        pushed     = 1;
        trans_drop = 1'b0;
      end
      if (m_hs) begin
        idx++;
        if (idx < 3) begin
          drive_m(1'b1, 10'h2A0, d[idx], 2'b00, (idx == 2), 4'hA);
          n_checks++;
          if (s_rid !== 10'h2A0 || s_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_master_untouched: got id=%h valid=%b, required 2a0 1", s_rid, s_rvalid);
          end
        end else begin
          drive_m(1'b0, '0, '0, 2'b00, 1'b0, '0);
        end
      end
    end
    trans_drop = 1'b0;
    n_checks++;
    if (!pushed || idx != 3) begin
      n_fail++;
      $display("FAIL mid_master_progress: got pushed=%0d beats=%0d, required 1 3", pushed, idx);
    end
    n_checks++;
    if (s_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_master_bubble: got valid=%b, required 0", s_rvalid);
    end
    cycle();
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rid !== 10'h003) begin
      n_fail++;
      $display("FAIL mid_master_drop_start: got valid=%b id=%h, required 1 003", s_rvalid, s_rid);
    end
    drain("mid_master", 20);
  endtask

  task automatic test_fifo_full();
    s_rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_drop(10'h010 + 10'(i), 8'(i % 3));
    end
    n_checks++;
    if (trans_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got %b, required 0", trans_ready);
    end
    trans_id   = 10'h3FF;
    trans_len  = 8'd5;
    trans_drop = 1'b1;
    cycle();
    trans_drop = 1'b0;
    n_checks++;
    if (d_hs !== 1'b0) begin
      n_fail++;
      $display("FAIL full_fifth_push: got accepted=%b, required 0", d_hs);
    end
    s_rready = 1'b1;
    drain("full", 60);
    for (int i = 0; i < 6; i++) cycle();
    n_checks++;
    if (trans_ready !== 1'b1 || s_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_after: got ready=%b valid=%b, required 1 0", trans_ready, s_rvalid);
    end
  endtask

  task automatic test_backpressure();
    int beats0;
    bit stalled = 0;
    logic [IDW-1:0] sv_id;
    logic sv_last;
    logic sv_valid;
    s_rready = 1'b1;
    beats0 = n_beats;
    push_drop(10'h2C5, 8'd7);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
      if (stalled) begin
        n_checks++;
        if (s_rid !== sv_id || s_rlast !== sv_last || s_rvalid !== sv_valid) begin
          n_fail++;
          $display("FAIL stall_stable: got id=%h last=%b valid=%b, required %h %b %b",
                   s_rid, s_rlast, s_rvalid, sv_id, sv_last, sv_valid);
        end
      end
      s_rready = (k % 2 == 0);
      sv_id    = s_rid;
      sv_last  = s_rlast;
      sv_valid = s_rvalid;
      stalled  = s_rvalid && !s_rready;
      cycle();
    end
    s_rready = 1'b1;
    drain("stall", 5);
    n_checks++;
    if (n_beats - beats0 !== 8) begin
      n_fail++;
      $display("FAIL stall_beat_count: got %0d, required 8", n_beats - beats0);
    end
  endtask

  task automatic test_reset_mid_burst();
    s_rready = 1'b1;
    push_drop(10'h0AB, 8'd5);
    cycle();
    cycle();
    cycle();
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rlast !== 1'b0 || s_rid !== 10'h0AB) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got valid=%b id=%h, required 1 0ab", s_rvalid, s_rid);
    end
    axi4_arstn = 1'b0;
    drive_m(1'b1, 10'h111, 64'hCAFE, 2'b00, 1'b0, 4'h1);
    exp_q.delete();
    #1;
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rid !== 10'h111 || trans_ready !== 1'b1 || m_rready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pass: got valid=%b id=%h ready=%b m_rready=%b, required 1 111 1 1",
               s_rvalid, s_rid, trans_ready, m_rready);
    end
    drive_m(1'b0, '0, '0, 2'b00, 1'b0, '0);
    cycle();
    axi4_arstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_checks++;
      if (s_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_no_beats: cycle %0d got valid=%b, required 0", i, s_rvalid);
      end
    end
  endtask

  task automatic test_drop_resp();
    s_rready = 1'b1;
    push_drop(10'h007, 8'd0);
    cycle();
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rresp !== DROP_RESP || s_rlast !== 1'b1 || s_rdata !== '0) begin
      n_fail++;
      $display("FAIL drop_resp: got valid=%b resp=%b last=%b data=%h, required 1 %b 1 0",
               s_rvalid, s_rresp, s_rlast, s_rdata, DROP_RESP);
    end
    drain("resp", 5);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_single_drop();
    test_drop_mid_master();
    test_fifo_full();
    test_backpressure();
    test_reset_mid_burst();
    test_drop_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
